// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall/flush controller for the 5-stage MIPS pipeline.
// Resolves load-use and ID-branch operand hazards that forwarding cannot cover.
module hazard_stall_ctrl #(
    parameter int CNT_W = 32,
    parameter int FL_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instru,
    input  logic [31:0]      ex_instru,
    input  logic [31:0]      mem_instru,
    input  logic             c_ex_RegWrite,
    input  logic             c_ex_MemRead,
    input  logic             c_mem_MemRead,
    input  logic             c_branch_taken,
    input  logic             c_mem_busy,
    output logic             c_pc_write,
    output logic             c_if_id_write,
    output logic             c_id_ex_bubble,
    output logic             c_if_id_flush,
    output logic             c_freeze,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [FL_W-1:0]  flush_count
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] S1   = 1'b1;

    logic [0:0] state;
    logic [0:0] state_nx;

    logic [5:0] id_op;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic [4:0] ex_w;
    logic [4:0] mem_w;
    logic       id_br;
    logic       id_use_rt;
    logic       ex_hit_any;
    logic       ex_hit_br;
    logic       mem_hit_br;
    logic       need2;
    logic       need1;
    logic       stall;
    logic       unused_bits;

    assign id_op = id_instru[31:26];
    assign id_rs = id_instru[25:21];
    assign id_rt = id_instru[20:16];

    assign ex_w  = (ex_instru[31:26] == 6'h00) ?
                   ex_instru[15:11] : ex_instru[20:16];
    assign mem_w = (mem_instru[31:26] == 6'h00) ?
                   mem_instru[15:11] : mem_instru[20:16];

    assign id_br     = (id_op == 6'h04) || (id_op == 6'h05);
    assign id_use_rt = (id_op == 6'h00) || id_br || (id_op == 6'h2B);

    // $zero is hardwired, so a write to it never creates a dependence
    assign ex_hit_br  = (ex_w != 5'd0) &&
                        ((ex_w == id_rs) || (ex_w == id_rt));
    assign ex_hit_any = (ex_w != 5'd0) &&
                        ((ex_w == id_rs) ||
                         (id_use_rt && (ex_w == id_rt)));
    assign mem_hit_br = (mem_w != 5'd0) &&
                        ((mem_w == id_rs) || (mem_w == id_rt));

    assign need2 = id_br && c_ex_MemRead && ex_hit_br;
    assign need1 = (c_ex_MemRead && ex_hit_any) ||
                   (id_br && c_ex_RegWrite &&
                    !c_ex_MemRead && ex_hit_br) ||
                   (id_br && c_mem_MemRead && mem_hit_br);

    assign stall = (state == S1) || need2 || need1;

    always_comb begin
        c_freeze       = 1'b0;
        c_pc_write     = 1'b1;
        c_if_id_write  = 1'b1;
        c_id_ex_bubble = 1'b0;
        c_if_id_flush  = 1'b0;
        if (c_mem_busy) begin
            c_freeze      = 1'b1;
            c_pc_write    = 1'b0;
            c_if_id_write = 1'b0;
        end else if (stall) begin
            c_pc_write     = 1'b0;
            c_if_id_write  = 1'b0;
            c_id_ex_bubble = 1'b1;
        end else begin
            c_if_id_flush = c_branch_taken;
        end
    end

    always_comb begin
        state_nx = state;
        if (!c_mem_busy) begin
            if (state == S1) state_nx = IDLE;
            else if (need2)  state_nx = S1;
            else             state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state <= state_nx;
            if (!c_mem_busy && stall)
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (c_if_id_flush)
                flush_count <= flush_count + FL_W'(1);
        end
    end

    assign unused_bits = ^{id_instru[15:0],
                           ex_instru[25:21], ex_instru[10:0],
                           mem_instru[25:21], mem_instru[10:0]};

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed-vector bench for hazard_stall_ctrl.
// Control outputs packed as {pc_write, if_id_write, bubble, flush, freeze}.
module tb_hazard_stall_ctrl;

    localparam logic [31:0] NOP    = 32'h0000_0000;
    localparam logic [31:0] LW_T0  = 32'h8C08_0000;
    localparam logic [31:0] ADD_U  = 32'h010A_4820;
    localparam logic [31:0] BEQ_01 = 32'h1109_0004;
    localparam logic [31:0] BNE_T0 = 32'h1500_0004;
    localparam logic [31:0] ADD_T0 = 32'h012A_4020;
    localparam logic [31:0] ADD_Z  = 32'h012A_0020;
    localparam logic [31:0] LW_T0B = 32'h8D48_0000;
    localparam logic [31:0] BEQ_23 = 32'h114B_0004;
    localparam logic [31:0] ADD_T2 = 32'h012A_5020;

    localparam logic [4:0] RUN = 5'b11000;
    localparam logic [4:0] STL = 5'b00100;
    localparam logic [4:0] FLS = 5'b11010;
    localparam logic [4:0] FRZ = 5'b00001;

    logic        clk;
    logic        rst_n;
    logic [31:0] id_instru;
    logic [31:0] ex_instru;
    logic [31:0] mem_instru;
    logic        c_ex_RegWrite;
    logic        c_ex_MemRead;
    logic        c_mem_MemRead;
    logic        c_branch_taken;
    logic        c_mem_busy;
    logic        c_pc_write;
    logic        c_if_id_write;
    logic        c_id_ex_bubble;
    logic        c_if_id_flush;
    logic        c_freeze;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    int n_cmp = 0;
    int n_bad = 0;

    hazard_stall_ctrl #(.CNT_W(32), .FL_W(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_instru      (id_instru),
        .ex_instru      (ex_instru),
        .mem_instru     (mem_instru),
        .c_ex_RegWrite  (c_ex_RegWrite),
        .c_ex_MemRead   (c_ex_MemRead),
        .c_mem_MemRead  (c_mem_MemRead),
        .c_branch_taken (c_branch_taken),
        .c_mem_busy     (c_mem_busy),
        .c_pc_write     (c_pc_write),
        .c_if_id_write  (c_if_id_write),
        .c_id_ex_bubble (c_id_ex_bubble),
        .c_if_id_flush  (c_if_id_flush),
        .c_freeze       (c_freeze),
        .stall_cycles   (stall_cycles),
        .flush_count    (flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] ctl();
        return {c_pc_write, c_if_id_write, c_id_ex_bubble,
                c_if_id_flush, c_freeze};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, check controls mid-cycle,
    // then check counters just after the clock edge.
    task automatic cyc(input string tag,
                       input logic [31:0] id, ex, mem,
                       input logic rw, exmr, memmr, bt, busy,
                       input logic [4:0] e_ctl,
                       input logic [31:0] e_sc,
                       input logic [15:0] e_fc);
        id_instru      = id;
        ex_instru      = ex;
        mem_instru     = mem;
        c_ex_RegWrite  = rw;
        c_ex_MemRead   = exmr;
        c_mem_MemRead  = memmr;
        c_branch_taken = bt;
        c_mem_busy     = busy;
        #1;
        chk({tag, ".ctl"}, {27'd0, ctl()}, {27'd0, e_ctl});
        @(posedge clk);
        #1;
        chk({tag, ".stall_cycles"}, stall_cycles, e_sc);
        chk({tag, ".flush_count"}, {16'd0, flush_count},
            {16'd0, e_fc});
    endtask

    initial begin
        rst_n          = 1'b0;
        id_instru      = NOP;
        ex_instru      = NOP;
        mem_instru     = NOP;
        c_ex_RegWrite  = 1'b0;
        c_ex_MemRead   = 1'b0;
        c_mem_MemRead  = 1'b0;
        c_branch_taken = 1'b0;
        c_mem_busy     = 1'b0;
        #2;
        chk("reset.ctl", {27'd0, ctl()}, {27'd0, RUN});
        chk("reset.sc", stall_cycles, 32'd0);
        chk("reset.fc", {16'd0, flush_count}, 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;

        // load-use: one stall, then run
        cyc("lu_stall", ADD_U, LW_T0, NOP, 1, 1, 0, 0, 0, STL, 1, 0);
        cyc("lu_after", ADD_U, NOP, LW_T0, 0, 0, 1, 0, 0, RUN, 1, 0);

        // lw then beq: two stalls, second ignores ex change
        cyc("lb_s0", BEQ_01, LW_T0, NOP, 1, 1, 0, 0, 0, STL, 2, 0);
        cyc("lb_s1", BEQ_01, NOP, NOP, 0, 0, 0, 0, 0, STL, 3, 0);
        cyc("lb_run", BEQ_01, NOP, NOP, 0, 0, 0, 0, 0, RUN, 3, 0);

        // ALU result feeding branch
        cyc("ab_stall", BNE_T0, ADD_T0, NOP, 1, 0, 0, 0, 0, STL, 4, 0);
        cyc("ab_run", BNE_T0, NOP, NOP, 0, 0, 0, 0, 0, RUN, 4, 0);
        cyc("ab_zero", BNE_T0, ADD_Z, NOP, 1, 0, 0, 0, 0, RUN, 4, 0);

        // load in MEM feeding branch
        cyc("bm_stall", BEQ_01, NOP, LW_T0, 0, 0, 1, 0, 0, STL, 5, 0);

        // lw does not read rt, so no hazard on rt
        cyc("lw_rt", LW_T0B, LW_T0, NOP, 1, 1, 0, 0, 0, RUN, 5, 0);

        // taken branch flush; stall beats flush
        cyc("fl_take", BEQ_23, NOP, NOP, 0, 0, 0, 1, 0, FLS, 5, 1);
        cyc("fl_stl", BEQ_23, ADD_T2, NOP, 1, 0, 0, 1, 0, STL, 6, 1);
        cyc("fl_after", BEQ_23, NOP, NOP, 0, 0, 0, 1, 0, FLS, 6, 2);

        // freeze while in S1 holds state and counters
        cyc("fz_enter", BEQ_01, LW_T0, NOP, 1, 1, 0, 0, 0, STL, 7, 2);
        cyc("fz_c0", BEQ_01, NOP, NOP, 0, 0, 0, 1, 1, FRZ, 7, 2);
        cyc("fz_c1", BEQ_01, NOP, NOP, 0, 0, 0, 1, 1, FRZ, 7, 2);
        cyc("fz_c2", BEQ_01, NOP, NOP, 0, 0, 0, 1, 1, FRZ, 7, 2);
        cyc("fz_s1", BEQ_01, NOP, NOP, 0, 0, 0, 1, 0, STL, 8, 2);
        cyc("fz_run", BEQ_01, NOP, NOP, 0, 0, 0, 0, 0, RUN, 8, 2);

        // freeze with a fresh hazard pending in IDLE
        cyc("fz_idle", ADD_U, LW_T0, NOP, 1, 1, 0, 0, 1, FRZ, 8, 2);
        cyc("fz_idle2", ADD_U, LW_T0, NOP, 1, 1, 0, 0, 0, STL, 9, 2);

        // async reset in the middle of S1
        cyc("rs_enter", BEQ_01, LW_T0, NOP, 1, 1, 0, 0, 0, STL, 10, 2);
        id_instru     = BEQ_01;
        ex_instru     = NOP;
        c_ex_RegWrite = 1'b0;
        c_ex_MemRead  = 1'b0;
        #1;
        chk("rs_in_s1.ctl", {27'd0, ctl()}, {27'd0, STL});
        #1 rst_n = 1'b0;
        #1;
        chk("rs_async.ctl", {27'd0, ctl()}, {27'd0, RUN});
        chk("rs_async.sc", stall_cycles, 32'd0);
        chk("rs_async.fc", {16'd0, flush_count}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        cyc("rs_run", BEQ_01, NOP, NOP, 0, 0, 0, 1, 0, FLS, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
